// File: rtl/fizzbuzz_sequencer.sv
// FizzBuzz line sequencer: clears the BCD counter each frame, presents one descriptor per text row,
// and steps the counter after each acknowledged line. Define FIZZBUZZ_SCROLL_EN to enable per-frame scrolling.
module fizzbuzz_sequencer #(
  parameter int ROWS          = 30,
  parameter int LIMIT         = 100,
  parameter int SCROLL_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       row_start,
  input  logic       line_ack,
  output logic       bcd_rst,
  output logic       bcd_increment,
  output logic       line_valid,
  output logic [1:0] line_class,
  output logic [5:0] line_index,
  output logic       done
);

  if (ROWS < 1 || ROWS > 63) begin : g_bad_rows
    $error("fizzbuzz_sequencer: ROWS must be 1..63");
  end
  if (LIMIT < 1 || LIMIT > 999) begin : g_bad_limit
    $error("fizzbuzz_sequencer: LIMIT must be 1..999");
  end
  if (SCROLL_FRAMES < 1) begin : g_bad_scroll
    $error("fizzbuzz_sequencer: SCROLL_FRAMES must be >= 1");
  end

  localparam logic [9:0] LIMIT_V  = 10'(LIMIT);
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PRELOAD,
    S_WAIT_ROW,
    S_PRESENT,
    S_ADVANCE,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] value_q, value_d;
  logic [1:0] m3_q, m3_d;
  logic [2:0] m5_q, m5_d;
  logic [5:0] row_q, row_d;

  // Residues are tracked incrementally so no divider is needed for the class decode.
  logic [9:0] value_inc;
  logic [1:0] m3_inc;
  logic [2:0] m5_inc;
  logic       last_line;

  assign value_inc = value_q + 10'd1;
  assign m3_inc    = (m3_q == 2'd2) ? 2'd0 : m3_q + 2'd1;
  assign m5_inc    = (m5_q == 3'd4) ? 3'd0 : m5_q + 3'd1;
  assign last_line = (row_q == ROW_LAST) || (value_q == LIMIT_V);

`ifdef FIZZBUZZ_SCROLL_EN
  localparam int         FCW         = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [9:0] OFFSET_LAST = 10'(LIMIT - 1);

  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [9:0]     offset_q, offset_d;
  logic [9:0]     preload_q, preload_d;

  // Offset moves on the same edge that enters CLEAR, so the new value applies to this frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    offset_d    = offset_q;
    if (frame_start) begin
      if (frame_cnt_q == FCW'(SCROLL_FRAMES - 1)) begin
        frame_cnt_d = '0;
        offset_d    = (offset_q == OFFSET_LAST) ? 10'd0 : offset_q + 10'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      offset_q    <= '0;
      preload_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      offset_q    <= offset_d;
      preload_q   <= preload_d;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    m3_d          = m3_q;
    m5_d          = m5_q;
    row_d         = row_q;
    bcd_rst       = 1'b0;
    bcd_increment = 1'b0;
    line_valid    = 1'b0;
    line_class    = 2'd0;
    line_index    = 6'd0;
    done          = 1'b0;
`ifdef FIZZBUZZ_SCROLL_EN
    preload_d     = preload_q;
`endif

    case (state_q)
      S_IDLE: ;
      S_CLEAR: begin
        bcd_rst = 1'b1;
        value_d = 10'd1;
        m3_d    = 2'd1;
        m5_d    = 3'd1;
        row_d   = 6'd0;
`ifdef FIZZBUZZ_SCROLL_EN
        preload_d = offset_q;
        state_d   = (offset_q != 10'd0) ? S_PRELOAD : S_WAIT_ROW;
`else
        state_d = S_WAIT_ROW;
`endif
      end
      S_PRELOAD: begin
`ifdef FIZZBUZZ_SCROLL_EN
        bcd_increment = 1'b1;
        value_d       = value_inc;
        m3_d          = m3_inc;
        m5_d          = m5_inc;
        preload_d     = preload_q - 10'd1;
        if (preload_q == 10'd1) state_d = S_WAIT_ROW;
`else
        state_d = S_WAIT_ROW;
`endif
      end
      S_WAIT_ROW: begin
        if (row_start) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        line_valid = 1'b1;
        line_index = row_q;
        if (m3_q == 2'd0 && m5_q == 3'd0) line_class = 2'd3;
        else if (m3_q == 2'd0)            line_class = 2'd1;
        else if (m5_q == 3'd0)            line_class = 2'd2;
        if (line_ack) state_d = last_line ? S_DONE : S_ADVANCE;
      end
      S_ADVANCE: begin
        bcd_increment = 1'b1;
        value_d       = value_inc;
        m3_d          = m3_inc;
        m5_d          = m5_inc;
        row_d         = row_q + 6'd1;
        state_d       = S_WAIT_ROW;
      end
      S_DONE: done = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // A new frame aborts whatever is in flight.
    if (frame_start) state_d = S_CLEAR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      value_q <= 10'd1;
      m3_q    <= 2'd1;
      m5_q    <= 3'd1;
      row_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      m3_q    <= m3_d;
      m5_q    <= m5_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// Scoreboard bench for fizzbuzz_sequencer: two instances (row-limited and value-limited) share random
// frame/row/ack stimulus; expected lines are queued by a plain-arithmetic model and checked by a monitor.
module tb_fizzbuzz_sequencer;
  localparam int SF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic row_start = 1'b0;
  logic line_ack = 1'b0;

  logic       brst [2];
  logic       binc [2];
  logic       lv   [2];
  logic       dn   [2];
  logic [1:0] lcls [2];
  logic [5:0] lidx [2];

  typedef struct {
    int idx;
    int cls;
    int val;
  } exp_t;

  exp_t q [2][$];
  exp_t e;

  int checks = 0;
  int failures = 0;

  int rows_p [2] = '{30, 12};
  int lim_p  [2] = '{100, 10};

  int m_val [2] = '{1, 1};
  int m_row [2] = '{0, 0};
  int m_off [2] = '{0, 0};
  int m_fc  [2] = '{0, 0};
  bit m_act [2] = '{0, 0};
  bit m_done[2] = '{0, 0};

  int exp_inc[2] = '{0, 0};
  int exp_rst[2] = '{0, 0};
  int mon_inc[2] = '{0, 0};
  int mon_rst[2] = '{0, 0};
  int sh     [2] = '{1, 1};

  always #5 clk = ~clk;

  fizzbuzz_sequencer #(.ROWS(30), .LIMIT(100), .SCROLL_FRAMES(SF)) u_a (
    .clk(clk), .rst(rst), .frame_start(frame_start), .row_start(row_start), .line_ack(line_ack),
    .bcd_rst(brst[0]), .bcd_increment(binc[0]), .line_valid(lv[0]), .line_class(lcls[0]),
    .line_index(lidx[0]), .done(dn[0])
  );

  fizzbuzz_sequencer #(.ROWS(12), .LIMIT(10), .SCROLL_FRAMES(SF)) u_b (
    .clk(clk), .rst(rst), .frame_start(frame_start), .row_start(row_start), .line_ack(line_ack),
    .bcd_rst(brst[1]), .bcd_increment(binc[1]), .line_valid(lv[1]), .line_class(lcls[1]),
    .line_index(lidx[1]), .done(dn[1])
  );

  function automatic int cls_of(input int v);
    if (v % 15 == 0) return 3;
    if (v % 3 == 0)  return 1;
    if (v % 5 == 0)  return 2;
    return 0;
  endfunction

  task automatic chk(input string name, input int i, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0d required=%0d t=%0t", name, i, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes pop the scoreboard; a shadow of the external BCD counter checks values.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (lv[i] && line_ack) begin
        if (q[i].size() == 0) begin
          chk("unexpected_line", i, 1'b0, int'(lidx[i]), -1);
        end else begin
          e = q[i].pop_front();
          chk("line_index", i, int'(lidx[i]) == e.idx, int'(lidx[i]), e.idx);
          chk("line_class", i, int'(lcls[i]) == e.cls, int'(lcls[i]), e.cls);
          chk("line_value", i, sh[i] == e.val, sh[i], e.val);
        end
      end
      if (brst[i] || binc[i]) chk("rst_inc_exclusive", i, !(brst[i] && binc[i]), int'(binc[i]), 0);
      if (brst[i]) mon_rst[i]++;
      if (binc[i]) mon_inc[i]++;
      if (rst || brst[i]) begin
        sh[i] = 1;
      end else if (binc[i]) begin
        chk("inc_below_limit", i, sh[i] < lim_p[i], sh[i], lim_p[i] - 1);
        sh[i]++;
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    for (int i = 0; i < 2; i++) begin
      chk(name, i, {brst[i], binc[i], lv[i], lcls[i], lidx[i], dn[i]} == 12'd0,
          int'({brst[i], binc[i], lv[i], lcls[i], lidx[i], dn[i]}), 0);
    end
  endtask

  task automatic check_counts();
    for (int i = 0; i < 2; i++) begin
      chk("inc_count", i, mon_inc[i] == exp_inc[i], mon_inc[i], exp_inc[i]);
      chk("rst_count", i, mon_rst[i] == exp_rst[i], mon_rst[i], exp_rst[i]);
    end
  endtask

  task automatic do_frame();
    int pre;
    pre = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
`ifdef FIZZBUZZ_SCROLL_EN
      m_fc[i] = (m_fc[i] + 1) % SF;
      if (m_fc[i] == 0) m_off[i] = (m_off[i] + 1) % lim_p[i];
`endif
      m_val[i] = 1 + m_off[i];
      m_row[i] = 0;
      m_act[i] = 1'b1;
      m_done[i] = 1'b0;
      exp_rst[i]++;
      exp_inc[i] += m_off[i];
      if (m_off[i] > pre) pre = m_off[i];
      chk("clear_bcd_rst", i, brst[i] == 1'b1, int'(brst[i]), 1);
      chk("clear_no_valid", i, lv[i] == 1'b0, int'(lv[i]), 0);
      chk("clear_done_low", i, dn[i] == 1'b0, int'(dn[i]), 0);
    end
    repeat (1 + pre) tick();
  endtask

  // One row: row_start, optional ack after dly cycles, then (if post) settle back to waiting.
  task automatic do_row(input int dly, input bit ack, input bit post);
    exp_t x;
    row_start = 1'b1;
    tick();
    row_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (m_act[i]) begin
        x.idx = m_row[i];
        x.cls = cls_of(m_val[i]);
        x.val = m_val[i];
        q[i].push_back(x);
      end
      chk("valid_latency", i, lv[i] == m_act[i], int'(lv[i]), int'(m_act[i]));
    end
    repeat (dly) tick();
    if (dly > 0)
      for (int i = 0; i < 2; i++) chk("valid_hold", i, lv[i] == m_act[i], int'(lv[i]), int'(m_act[i]));
    if (!ack) return;
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (m_act[i]) begin
        if (m_row[i] == rows_p[i] - 1 || m_val[i] == lim_p[i]) begin
          m_act[i] = 1'b0;
          m_done[i] = 1'b1;
        end else begin
          m_val[i]++;
          m_row[i]++;
          exp_inc[i]++;
        end
      end
      chk("done_state", i, dn[i] == m_done[i], int'(dn[i]), int'(m_done[i]));
      chk("valid_drop", i, lv[i] == 1'b0, int'(lv[i]), 0);
    end
    if (post) begin
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check_idle_outputs("reset_outputs");
    rst = 1'b0;
    tick();
    do_row(0, 1'b0, 1'b0);
    repeat (2) tick();

    // First frame: 15 lines from value 1.
    do_frame();
    repeat (15) do_row($urandom_range(0, 3), 1'b1, 1'b1);
    check_counts();

    // Random frame lengths; dut1 runs into LIMIT, dut0 into ROWS on long frames.
    for (int f = 0; f < 5; f++) begin
      do_frame();
      n = (f == 1) ? 34 : int'($urandom_range(8, 34));
      for (int r = 0; r < n; r++) do_row($urandom_range(0, 3), 1'b1, 1'b1);
      check_counts();
    end

    // Frame restart while row 5 awaits its ack.
    do_frame();
    repeat (5) do_row($urandom_range(0, 2), 1'b1, 1'b1);
    do_row(2, 1'b0, 1'b0);
    do_frame();
    repeat (2) do_row($urandom_range(0, 2), 1'b1, 1'b1);
    check_counts();

    // Reset while the increment cycle is active.
    do_row(1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_idle_outputs("reset_in_advance");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0;
      m_done[i] = 1'b0;
      m_fc[i] = 0;
      m_off[i] = 0;
      q[i].delete();
    end
    tick();
    do_row(1, 1'b0, 1'b0);
    repeat (2) tick();
    check_counts();

    do_frame();
    repeat (12) do_row($urandom_range(0, 3), 1'b1, 1'b1);
    repeat (3) tick();
    check_counts();
    for (int i = 0; i < 2; i++) chk("queue_drained", i, q[i].size() == 0, q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
